// File: rtl/io_bus_arbiter_pkg.sv
// Shared types for the user-IO bus arbiter.
// Holds the FSM state enum, size limits and index-width helper.
package io_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_SAMPLE,
    S_TURN,
    S_DONE
  } io_arb_state_t;

  localparam int MAX_NREQ = 8;
  localparam int MAX_TURN = 7;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_picker.sv
// Round-robin picker: first set req bit after last_i, wrapping.
// Ports: req_i, last_i in; valid_o, idx_o out. Purely combinational.
module rr_picker
  import io_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req_i,
  input  logic [idx_w(NREQ)-1:0] last_i,
  output logic                   valid_o,
  output logic [idx_w(NREQ)-1:0] idx_o
);

  localparam int IW = idx_w(NREQ);

  // Walk from the farthest candidate to the nearest so the
  // nearest set bit after last_i is the one left standing.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % NREQ]) begin
        valid_o = 1'b1;
        idx_o   = IW'((int'(last_i) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one bidirectional pin bus among NREQ requesters.
// Ports: req/we/wdata in, grant/done/rdata out, bus_in/out/oeb/strobe.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int TURN_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] we,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0] grant,
  output logic            done,
  output logic [DW-1:0]   rdata,
  input  logic [DW-1:0]   bus_in,
  output logic [DW-1:0]   bus_out,
  output logic [DW-1:0]   bus_oeb,
  output logic            bus_strobe
);

  localparam int IW = idx_w(NREQ);

  io_arb_state_t   state_q;
  logic [IW-1:0]   last_q;
  logic [2:0]      turn_q;
  logic [NREQ-1:0] grant_q;
  logic            done_q;
  logic [DW-1:0]   rdata_q;
  logic [DW-1:0]   bus_out_q;
  logic [DW-1:0]   bus_oeb_q;
  logic            strobe_q;

  logic            pick_v;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] gnt_oh;
  logic            we_sel;
  logic [DW-1:0]   wd_sel;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_v),
    .idx_o   (pick_idx)
  );

  always_comb begin
    gnt_oh = '0;
    we_sel = 1'b0;
    wd_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        gnt_oh[i] = 1'b1;
        we_sel    = we[i];
        wd_sel    = wdata[i*DW +: DW];
      end
    end
  end

  // Outputs are loaded on entry to each state, so the pads
  // only ever see registered values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= IW'(NREQ - 1);
      turn_q    <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      bus_out_q <= '0;
      bus_oeb_q <= '1;
      strobe_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_v) begin
            last_q   <= pick_idx;
            grant_q  <= gnt_oh;
            strobe_q <= 1'b1;
            if (we_sel) begin
              bus_out_q <= wd_sel;
              bus_oeb_q <= '0;
              state_q   <= S_WRITE;
            end else begin
              state_q   <= S_READ;
            end
          end
        end
        S_WRITE: begin
          bus_oeb_q <= '1;
          strobe_q  <= 1'b0;
          if (TURN_CYC > 0) begin
            turn_q  <= 3'(TURN_CYC);
            state_q <= S_TURN;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_TURN: begin
          if (turn_q <= 3'd1) begin
            turn_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            turn_q  <= turn_q - 3'd1;
          end
        end
        S_READ: begin
          strobe_q <= 1'b0;
          state_q  <= S_SAMPLE;
        end
        S_SAMPLE: begin
          rdata_q <= bus_in;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          grant_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign bus_out    = bus_out_q;
  assign bus_oeb    = bus_oeb_q;
  assign bus_strobe = strobe_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter (NREQ=4, DW=8, TURN_CYC=1).
// Transaction-level model: round-robin pick plus per-op cycle timing.
module tb_io_bus_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TURN = 1;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] we;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0] grant;
  logic            done;
  logic [DW-1:0]   rdata;
  logic [DW-1:0]   bus_in;
  logic [DW-1:0]   bus_out;
  logic [DW-1:0]   bus_oeb;
  logic            bus_strobe;

  int checks;
  int errors;
  int m_last;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_bus_out;

  logic [NREQ-1:0] next_req;
  logic [NREQ-1:0] next_we;
  logic [NREQ*DW-1:0] next_wdata;
  bit drop_mid;

  io_bus_arbiter #(.NREQ(NREQ), .DW(DW), .TURN_CYC(TURN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .wdata      (wdata),
    .grant      (grant),
    .done       (done),
    .rdata      (rdata),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oeb    (bus_oeb),
    .bus_strobe (bus_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = NREQ - 1;
    m_rdata = '0;
    m_bus_out = '0;
  endtask

  // Called at a negedge with req/we/wdata already applied.
  // Follows one transaction to its DONE negedge.
  task automatic do_txn(input int exp_lat, input logic [DW-1:0] rd_val,
                        output int got);
    int n;
    int idx;
    logic w;
    logic [DW-1:0] wd;
    logic [NREQ-1:0] eg;
    idx = pick(req, m_last);
    w = we[idx];
    wd = wdata[idx*DW +: DW];
    eg = '0;
    eg[idx] = 1'b1;
    got = -1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant === '0 && n < 8);
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL latency: got %0d cycles, need %0d", n, exp_lat);
    end
    if (grant === '0) begin
      errors++;
      $display("FAIL grant_timeout: grant %b, need %b", grant, eg);
      return;
    end
    for (int i = 0; i < NREQ; i++) if (grant[i]) got = i;
    checks++;
    if (grant !== eg || $countones(grant) != 1) begin
      errors++;
      $display("FAIL grant: got %b, need %b", grant, eg);
    end
    if (drop_mid) req = '0;
    if (w) begin
      m_bus_out = wd;
      checks++;
      if (bus_out !== wd || bus_oeb !== 8'h00 || bus_strobe !== 1'b1 ||
          done !== 1'b0) begin
        errors++;
        $display("FAIL write_cyc: out %h oeb %h stb %b done %b, need %h 00 1 0",
                 bus_out, bus_oeb, bus_strobe, done, wd);
      end
      for (int t = 0; t < TURN; t++) begin
        @(negedge clk);
        checks++;
        if (bus_oeb !== 8'hFF || bus_strobe !== 1'b0 || done !== 1'b0 ||
            grant !== eg) begin
          errors++;
          $display("FAIL turn: oeb %h stb %b done %b gnt %b, need FF 0 0 %b",
                   bus_oeb, bus_strobe, done, grant, eg);
        end
      end
    end else begin
      checks++;
      if (bus_oeb !== 8'hFF || bus_strobe !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL read_cyc: oeb %h stb %b done %b, need FF 1 0",
                 bus_oeb, bus_strobe, done);
      end
      bus_in = rd_val;
      @(negedge clk);
      checks++;
      if (bus_oeb !== 8'hFF || bus_strobe !== 1'b0 || done !== 1'b0 ||
          grant !== eg) begin
        errors++;
        $display("FAIL sample: oeb %h stb %b done %b gnt %b, need FF 0 0 %b",
                 bus_oeb, bus_strobe, done, grant, eg);
      end
      m_rdata = rd_val;
    end
    @(negedge clk);
    bus_in = DW'($urandom);
    checks++;
    if (done !== 1'b1 || grant !== eg || rdata !== m_rdata ||
        bus_oeb !== 8'hFF || bus_strobe !== 1'b0 || bus_out !== m_bus_out) begin
      errors++;
      $display("FAIL done: done %b gnt %b rdata %h oeb %h out %h, need 1 %b %h FF %h",
               done, grant, rdata, bus_oeb, bus_out, eg, m_rdata, m_bus_out);
    end
    m_last = idx;
    req = next_req;
    we = next_we;
    wdata = next_wdata;
    drop_mid = 1'b0;
  endtask

  task automatic test_reset();
    int g;
    rst_n = 1'b0;
    req = '1;
    we = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus_oeb !== 8'hFF || grant !== '0 || done !== 1'b0 ||
          bus_strobe !== 1'b0 || bus_out !== '0 || rdata !== '0) begin
        errors++;
        $display("FAIL reset: oeb %h gnt %b done %b stb %b out %h rd %h",
                 bus_oeb, grant, done, bus_strobe, bus_out, rdata);
      end
    end
    rst_n = 1'b1;
    m_last = NREQ - 1;
    m_rdata = '0;
    m_bus_out = '0;
    next_req = '0;
    next_we = '0;
    next_wdata = '0;
    do_txn(1, 8'h77, g);
    checks++;
    if (g !== 0) begin
      errors++;
      $display("FAIL first_grant: got %0d, need 0", g);
    end
  endtask

  task automatic test_write();
    int g;
    @(negedge clk);
    req = 4'b0001;
    we = 4'b0001;
    wdata = 32'h000000A5;
    next_req = '0;
    do_txn(1, 8'h00, g);
  endtask

  task automatic test_read();
    int g;
    @(negedge clk);
    req = 4'b0100;
    we = 4'b0000;
    next_req = '0;
    do_txn(1, 8'h3C, g);
    checks++;
    if (g !== 2) begin
      errors++;
      $display("FAIL read_grant: got %0d, need 2", g);
    end
  endtask

  task automatic test_back_to_back();
    int g;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    req = '1;
    we = 4'($urandom);
    wdata = $urandom;
    for (int i = 0; i < 5; i++) begin
      next_req = (i == 4) ? '0 : '1;
      next_we = 4'($urandom);
      next_wdata = $urandom;
      do_txn(i == 0 ? 1 : 2, DW'($urandom), g);
      checks++;
      if (g !== order[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d, need %0d", i, g, order[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int g;
    int exp[3];
    logic [NREQ-1:0] rq[3];
    exp = '{3, 0, 3};
    rq = '{4'b1000, 4'b1001, 4'b1001};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = rq[i];
      we = 4'($urandom);
      next_req = '0;
      do_txn(1, DW'($urandom), g);
      checks++;
      if (g !== exp[i]) begin
        errors++;
        $display("FAIL wrap[%0d]: got %0d, need %0d", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int g;
    @(negedge clk);
    req = 4'b0001;
    we = 4'b0001;
    wdata = 32'h0000005A;
    @(negedge clk);
    checks++;
    if (bus_oeb !== 8'h00) begin
      errors++;
      $display("FAIL pre_rst_write: oeb %h, need 00", bus_oeb);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_oeb !== 8'hFF || grant !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: oeb %h gnt %b done %b, need FF 0000 0",
               bus_oeb, grant, done);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bus_out !== '0) begin
      errors++;
      $display("FAIL rst_hold: done %b out %h, need 0 00", done, bus_out);
    end
    rst_n = 1'b1;
    m_last = NREQ - 1;
    m_rdata = '0;
    m_bus_out = '0;
    @(negedge clk);
    req = 4'b0010;
    we = 4'b0010;
    wdata = 32'h0000C300;
    next_req = '0;
    do_txn(1, 8'h00, g);
    checks++;
    if (g !== 1) begin
      errors++;
      $display("FAIL post_rst: got %0d, need 1", g);
    end
  endtask

  task automatic test_random();
    int g;
    @(negedge clk);
    req = 4'($urandom_range(1, 15));
    we = 4'($urandom);
    wdata = $urandom;
    for (int i = 0; i < 40; i++) begin
      next_req = (i == 39) ? '0 : 4'($urandom_range(1, 15));
      next_we = 4'($urandom);
      next_wdata = $urandom;
      drop_mid = ($urandom_range(0, 3) == 0);
      do_txn(i == 0 ? 1 : 2, DW'($urandom), g);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req = '0;
    we = '0;
    wdata = '0;
    bus_in = '0;
    drop_mid = 1'b0;
    m_last = NREQ - 1;
    m_rdata = '0;
    m_bus_out = '0;
    next_req = '0;
    next_we = '0;
    next_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_wrap();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
